// File: rtl/imm_extend_unit.sv
// Immediate extension unit with a valid/ready handshake on both sides.
// One output register plus a skid register allow full throughput with a registered in_ready.
module imm_extend_unit #(
  parameter int IN_W  = 6,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] xfer_count
);

  logic [OUT_W-1:0] zeroExt;
  logic [OUT_W-1:0] signExt;
  logic [OUT_W-1:0] extResult;

  logic             outValid_q, outValid_d;
  logic [OUT_W-1:0] outData_q, outData_d;
  logic             skidValid_q, skidValid_d;
  logic [OUT_W-1:0] skidData_q, skidData_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic accept;
  logic deliver;
  logic outFree;

  // Sign extension ORs ones above the field, so it stays legal when OUT_W == IN_W.
  always_comb begin
    zeroExt   = OUT_W'(in_imm);
    signExt   = zeroExt | ({OUT_W{in_imm[IN_W-1]}} << IN_W);
    extResult = zeroExt;
    unique case (in_mode)
      2'd0: extResult = zeroExt;
      2'd1: extResult = signExt;
      2'd2: extResult = signExt << SHIFT;
      2'd3: extResult = zeroExt << (OUT_W - IN_W);
    endcase
  end

  assign accept  = in_valid && !skidValid_q;
  assign deliver = outValid_q && out_ready;
  assign outFree = !outValid_q || out_ready;

  always_comb begin
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    count_d     = deliver ? count_q + 1'b1 : count_q;

    if (outFree) begin
      if (skidValid_q) begin
        outValid_d  = 1'b1;
        outData_d   = skidData_q;
        skidValid_d = 1'b0;
      end else if (accept) begin
        outValid_d = 1'b1;
        outData_d  = extResult;
      end else begin
        outValid_d = 1'b0;
      end
    end else if (accept) begin
      // Output is stalled, so the new result parks in the skid slot.
      skidValid_d = 1'b1;
      skidData_d  = extResult;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
      count_q     <= '0;
    end else begin
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
      count_q     <= count_d;
    end
  end

  assign in_ready   = !skidValid_q;
  assign out_valid  = outValid_q;
  assign out_data   = outData_q;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: queue-based reference model checked every
// cycle, plus directed literal checks for each extension mode, backpressure and reset.
module tb_imm_extend_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] xfer_count;

  logic        in_ready_s;
  logic        out_valid_s;
  logic [31:0] out_data_s;
  logic [3:0]  xfer_count_s;

  int checks = 0;
  int errors = 0;

  logic [31:0] expQ[$];
  int          delivered = 0;

  imm_extend_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .xfer_count(xfer_count)
  );

  imm_extend_unit #(.CNT_W(4)) dutSmall (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .xfer_count(xfer_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Extension computed as plain integer arithmetic on the value the field represents.
  function automatic logic [31:0] refExt(input logic [5:0] imm, input logic [1:0] mode);
    longint u;
    longint s;
    longint r;
    u = longint'(imm);
    s = (u >= 32) ? u - 64 : u;
    case (mode)
      2'd0:    r = u;
      2'd1:    r = s;
      2'd2:    r = s * 4;
      default: r = u * 64'd67108864;
    endcase
    return r[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] imm, input logic [1:0] mode,
                               input logic rdy);
    in_valid  = v;
    in_imm    = imm;
    in_mode   = mode;
    out_ready = rdy;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
  endtask

  // Model: expQ holds every accepted-but-undelivered result in acceptance order.
  always @(negedge clk) begin
    logic modelAccept;
    logic modelDeliver;
    if (reset) begin
      expQ.delete();
      delivered = 0;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_data", out_data, 32'd0);
      checkOutput("rst_xfer_count", 32'(xfer_count), 32'd0);
    end else begin
      modelAccept  = in_valid && (expQ.size() < 2);
      modelDeliver = out_ready && (expQ.size() > 0);
      checkOutput("in_ready", 32'(in_ready), 32'(expQ.size() < 2));
      checkOutput("out_valid", 32'(out_valid), 32'(expQ.size() > 0));
      if (expQ.size() > 0) begin
        checkOutput("out_data", out_data, expQ[0]);
        checkOutput("out_data_small", out_data_s, expQ[0]);
      end
      checkOutput("xfer_count", 32'(xfer_count), 32'(delivered % 65536));
      checkOutput("xfer_count_small", 32'(xfer_count_s), 32'(delivered % 16));
      if (modelDeliver) begin
        void'(expQ.pop_front());
        delivered++;
      end
      if (modelAccept) expQ.push_back(refExt(in_imm, in_mode));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 6'h00, 2'd0, 1'b0);
    repeat (2) stepCycle();
    reset = 1'b0;

    // One transfer per mode, one cycle latency each.
    applyStimulus(1'b1, 6'h2D, 2'd0, 1'b1);
    stepCycle();
    checkOutput("mode0_2D", out_data, 32'h0000002D);
    applyStimulus(1'b1, 6'h2D, 2'd1, 1'b1);
    stepCycle();
    checkOutput("mode1_2D", out_data, 32'hFFFFFFED);
    applyStimulus(1'b1, 6'h2D, 2'd2, 1'b1);
    stepCycle();
    checkOutput("mode2_2D", out_data, 32'hFFFFFFB4);
    applyStimulus(1'b1, 6'h2D, 2'd3, 1'b1);
    stepCycle();
    checkOutput("mode3_2D", out_data, 32'hB4000000);
    applyStimulus(1'b1, 6'h1F, 2'd1, 1'b1);
    stepCycle();
    checkOutput("mode1_1F", out_data, 32'h0000001F);
    applyStimulus(1'b1, 6'h1F, 2'd2, 1'b1);
    stepCycle();
    checkOutput("mode2_1F", out_data, 32'h0000007C);
    applyStimulus(1'b0, 6'h00, 2'd0, 1'b1);
    stepCycle();
    checkOutput("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure fills output then skid.
    applyStimulus(1'b1, 6'h01, 2'd0, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 6'h02, 2'd0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 6'h00, 2'd3, 1'b0);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_hold1", out_data, 32'h00000001);
    stepCycle();
    checkOutput("bp_hold2", out_data, 32'h00000001);
    applyStimulus(1'b0, 6'h00, 2'd3, 1'b1);
    checkOutput("bp_first", out_data, 32'h00000001);
    stepCycle();
    checkOutput("bp_second", out_data, 32'h00000002);
    checkOutput("bp_ready_back", 32'(in_ready), 32'd1);
    stepCycle();
    checkOutput("bp_empty", 32'(out_valid), 32'd0);

    // Asynchronous reset with both registers full.
    applyStimulus(1'b1, 6'h03, 2'd1, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 6'h05, 2'd2, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 6'h00, 2'd0, 1'b0);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    checkOutput("pre_rst_count", 32'(xfer_count), 32'd8);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_in_ready", 32'(in_ready), 32'd1);
    checkOutput("async_count", 32'(xfer_count), 32'd0);
    stepCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 6'h00, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("no_stale", 32'(out_valid), 32'd0);
    end

    // Streaming, 100 random transfers with no bubbles.
    pulseReset();
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 6'($urandom), 2'($urandom), 1'b1);
      stepCycle();
      checkOutput("stream_valid", 32'(out_valid), 32'd1);
    end
    applyStimulus(1'b0, 6'h00, 2'd0, 1'b1);
    repeat (2) stepCycle();
    checkOutput("stream_count", 32'(xfer_count), 32'd100);

    // Small counter wraps 15 -> 0 -> 1.
    pulseReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 6'($urandom), 2'($urandom), 1'b1);
      stepCycle();
      if (i == 15) checkOutput("wrap_15", 32'(xfer_count_s), 32'd15);
      if (i == 16) checkOutput("wrap_0", 32'(xfer_count_s), 32'd0);
    end
    applyStimulus(1'b0, 6'h00, 2'd0, 1'b1);
    repeat (2) stepCycle();
    checkOutput("wrap_1", 32'(xfer_count_s), 32'd1);
    checkOutput("wrap_big", 32'(xfer_count), 32'd17);

    // Random valid/ready traffic exercising the skid path.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom), 6'($urandom), 2'($urandom), 1'($urandom));
      stepCycle();
    end
    applyStimulus(1'b0, 6'h00, 2'd0, 1'b1);
    repeat (3) stepCycle();
    checkOutput("final_drain", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_unit.md
IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

Interface
REQ-001 The block SHALL take parameter IN_W, default 6: immediate field width in bits.
REQ-002 The block SHALL take parameter OUT_W, default 32: extended result width in bits.
REQ-003 The block SHALL take parameter SHIFT, default 2: left-shift amount applied in mode 2.
REQ-004 The block SHALL take parameter CNT_W, default 16: width of the completed-transfer counter.
REQ-005 clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  upstream presents an immediate.
REQ-008 in_ready  output  1  block can accept an immediate this cycle.
REQ-009 in_imm  input  IN_W  raw immediate field.
REQ-010 in_mode  input  2  extension mode: 0 zero-extend, 1 sign-extend, 2 sign-extend then shift left by SHIFT, 3 upper-place.
REQ-011 out_valid  output  1  out_data holds a result.
REQ-012 out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 out_data  output  OUT_W  extended result.
REQ-014 xfer_count  output  CNT_W  number of results delivered downstream since reset.

Function
REQ-015 Legal parameters SHALL be IN_W >= 2 and OUT_W >= IN_W + SHIFT; no bit of the shifted immediate is ever discarded.
REQ-016 Mode 0 SHALL produce in_imm in bits [IN_W-1:0] and zeros in all upper bits.
REQ-017 Mode 1 SHALL replicate in_imm[IN_W-1] into bits [OUT_W-1:IN_W].
REQ-018 Mode 2 SHALL produce the mode-1 result shifted left by SHIFT, with zeros in the low SHIFT bits.
REQ-019 Mode 3 SHALL place in_imm in bits [OUT_W-1:OUT_W-IN_W] and zeros in all lower bits.
REQ-020 The mode SHALL be sampled with in_imm at acceptance and travel with the data; later changes to in_mode SHALL NOT affect held results.
REQ-021 Acceptance SHALL occur when in_valid and in_ready are both high at a rising edge.
REQ-022 Delivery SHALL occur when out_valid and out_ready are both high at a rising edge.
REQ-023 Storage SHALL be one output register (out_valid/out_data) plus one skid register (skid_valid/skid_data).
REQ-024 in_ready SHALL equal NOT skid_valid, driven from a register and independent of same-cycle out_ready.
REQ-025 Latency SHALL be 1 cycle: data accepted at edge N is on out_data with out_valid high after edge N when the output register is empty or being delivered at edge N.
REQ-026 When the output register is empty or delivered at an edge, it SHALL load from skid (clearing skid_valid) if skid_valid is high; otherwise from the accepted input; otherwise out_valid SHALL clear.
REQ-027 When out_valid is high and out_ready is low at an edge with acceptance, the result SHALL load into skid and skid_valid SHALL set.
REQ-028 Sustained in_valid and out_ready SHALL give one result per cycle with no bubbles.
REQ-029 Results SHALL be delivered in acceptance order, none dropped or duplicated.
REQ-030 out_data and out_valid SHALL remain stable while out_valid is high and out_ready is low.
REQ-031 xfer_count SHALL increment by 1 on each delivery and wrap from 2^CNT_W-1 to 0.

Reset
REQ-032 While reset is high: out_valid = 0, skid_valid = 0, in_ready = 1, out_data = 0, xfer_count = 0, taking effect immediately without a clock edge.
REQ-033 Reset asserted mid-transfer SHALL discard both held results; the first edge after release SHALL behave as from an empty block.

Verification
REQ-034 Defaults, in_imm = 6'h2D, one transfer per mode 0/1/2/3 with out_ready high -> out_data = 0x0000002D, 0xFFFFFFED, 0xFFFFFFB4, 0xB4000000, each one cycle after acceptance.
REQ-035 in_imm = 6'h1F in mode 1 -> 0x0000001F; in mode 2 -> 0x0000007C.
REQ-036 Backpressure: out_ready low, present 0x01 then 0x02 in mode 0 -> both accepted, in_ready low after the second, out_data held at 0x00000001; raise out_ready -> 0x00000001 then 0x00000002 on consecutive cycles, in_ready returns high.
REQ-037 Streaming: 100 random immediates and modes with in_valid and out_ready held high -> 100 deliveries on consecutive cycles, all matching the reference model, xfer_count = 100.
REQ-038 With output and skid both full, assert reset asynchronously between edges -> out_valid and in_ready change immediately to 0 and 1; xfer_count reads 0; no stale result appears after release.
REQ-039 CNT_W = 4, 17 deliveries -> xfer_count wraps 15 -> 0 and reads 1.
